// File: rtl/requant_stream.sv
// requant_stream: three-stage requantiser (multiply, round-shift, offset+saturate) driving argmax_cell.
// Build option REQUANT_RELU_EN adds a fused ReLU that clamps results below cfg_zp up to cfg_zp.
module requant_stream #(
    parameter int ACC_WIDTH   = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int MULT_WIDTH  = 16,
    parameter int INDEX_WIDTH = 10,
    parameter int CELL_AMOUNT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          acc_valid,
    output logic                          acc_ready,
    input  logic signed [ACC_WIDTH-1:0]   acc_data,
    input  logic signed [MULT_WIDTH-1:0]  cfg_mult,
    input  logic        [5:0]             cfg_shift,
    input  logic signed [DATA_WIDTH-1:0]  cfg_zp,
    output logic        [INDEX_WIDTH-1:0] out_index,
    output logic signed [DATA_WIDTH-1:0]  out_value,
    output logic                          out_enable,
    output logic                          frame_done
);
    localparam int PW = ACC_WIDTH + MULT_WIDTH;
    localparam int SW = PW + 1;  // one guard bit so the rounding add cannot overflow
    localparam int TW = SW + 1;
    localparam logic signed [TW-1:0] SAT_MAX = TW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [TW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(CELL_AMOUNT - 1);

    function automatic logic signed [SW-1:0] round_shift(input logic signed [PW-1:0] p,
                                                         input logic [5:0] sh);
        logic signed [SW-1:0] ext;
        logic signed [SW-1:0] half;
        ext  = SW'(p);
        half = SW'(1) <<< (sh - 6'd1);
        return (sh == 6'd0) ? ext : ((ext + half) >>> sh);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [TW-1:0] v);
        if (v > SAT_MAX)
            return DATA_WIDTH'(SAT_MAX);
        else if (v < SAT_MIN)
            return DATA_WIDTH'(SAT_MIN);
        return DATA_WIDTH'(v);
    endfunction

    logic                          vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic signed [PW-1:0]          prod_p1_q, prod_p1_d;
    logic        [5:0]             shift_p1_q, shift_p1_d;
    logic signed [DATA_WIDTH-1:0]  zp_p1_q, zp_p1_d, zp_p2_q, zp_p2_d;
    logic signed [SW-1:0]          shifted_p2_q, shifted_p2_d;
    logic signed [TW-1:0]          sum_p3;
    logic signed [DATA_WIDTH-1:0]  val_p3;
    logic        [INDEX_WIDTH-1:0] cnt_q, cnt_d, out_index_q, out_index_d;
    logic signed [DATA_WIDTH-1:0]  out_value_q, out_value_d;
    logic                          out_enable_q, out_enable_d, frame_done_q, frame_done_d;

    assign acc_ready  = ~rst;
    assign out_index  = out_index_q;
    assign out_value  = out_value_q;
    assign out_enable = out_enable_q;
    assign frame_done = frame_done_q;

    always_comb begin
        // stage 1: full-precision product
        vld_p1_d   = acc_valid & ~rst;
        prod_p1_d  = PW'(acc_data) * PW'(cfg_mult);
        shift_p1_d = cfg_shift;
        zp_p1_d    = cfg_zp;
        // stage 2: half-up rounding arithmetic shift
        vld_p2_d     = vld_p1_q;
        shifted_p2_d = round_shift(prod_p1_q, shift_p1_q);
        zp_p2_d      = zp_p1_q;
        // stage 3: zero-point offset, saturation, indexing
        sum_p3 = TW'(shifted_p2_q) + TW'(zp_p2_q);
        val_p3 = saturate(sum_p3);
`ifdef REQUANT_RELU_EN
        if (val_p3 < zp_p2_q)
            val_p3 = zp_p2_q;
`endif
        out_enable_d = vld_p2_q;
        out_value_d  = vld_p2_q ? val_p3 : '0;
        out_index_d  = vld_p2_q ? cnt_q : '0;
        frame_done_d = vld_p2_q && (cnt_q == LAST_IDX);
        cnt_d        = cnt_q;
        if (vld_p2_q)
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + INDEX_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            cnt_q        <= '0;
            out_index_q  <= '0;
            out_value_q  <= '0;
            out_enable_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
            cnt_q        <= cnt_d;
            out_index_q  <= out_index_d;
            out_value_q  <= out_value_d;
            out_enable_q <= out_enable_d;
            frame_done_q <= frame_done_d;
        end
    end

    // datapath registers carry no reset; the valids qualify them
    always_ff @(posedge clk) begin
        prod_p1_q    <= prod_p1_d;
        shift_p1_q   <= shift_p1_d;
        zp_p1_q      <= zp_p1_d;
        shifted_p2_q <= shifted_p2_d;
        zp_p2_q      <= zp_p2_d;
    end
endmodule

// File: tb/tb_requant_stream.sv
// Scoreboard bench for requant_stream: expected records queued at send time, observed records
// captured on the falling edge whenever out_enable is high.
module tb_requant_stream;
    logic               clk;
    logic               rst;
    logic               acc_valid;
    logic               acc_ready;
    logic signed [31:0] acc_data;
    logic signed [15:0] cfg_mult;
    logic        [5:0]  cfg_shift;
    logic signed [7:0]  cfg_zp;
    logic        [9:0]  out_index;
    logic signed [7:0]  out_value;
    logic               out_enable;
    logic               frame_done;

    requant_stream dut (
        .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_data(acc_data), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
        .out_index(out_index), .out_value(out_value), .out_enable(out_enable),
        .frame_done(frame_done)
    );

    typedef struct packed {
        int         cyc;
        logic [9:0] idx;
        logic [7:0] val;
        logic       fd;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   model_idx = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (out_enable === 1'b1)
            obs_q.push_back('{cyc, out_index, out_value, frame_done});

    function automatic string fmt(rec_t r);
        return $sformatf("cyc=%0d idx=%0d val=%0d fd=%b", r.cyc, r.idx, $signed(r.val), r.fd);
    endfunction

    function automatic logic [7:0] model(int acc, int mult, int sh, int zp);
        longint p, s, v;
        p = longint'(acc) * longint'(mult);
        s = (sh == 0) ? p : ((p + (longint'(1) <<< (sh - 1))) >>> sh);
        v = s + longint'(zp);
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
`ifdef REQUANT_RELU_EN
        if (v < zp) v = zp;
`endif
        return 8'(v);
    endfunction

    task automatic send(input int acc, input int mult, input int sh, input int zp,
                        input logic [7:0] expv, input bit chk);
        @(posedge clk); #1;
        acc_valid = 1'b1;
        acc_data  = acc;
        cfg_mult  = 16'(mult);
        cfg_shift = 6'(sh);
        cfg_zp    = 8'(zp);
        if (chk) begin
            exp_q.push_back('{cyc + 3, 10'(model_idx), expv, model_idx == 3});
            model_idx = (model_idx == 3) ? 0 : model_idx + 1;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        acc_valid = 1'b0;
        acc_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; acc_valid = 1'b1; acc_data = 32'sd77;
        cfg_mult = 16'sd1; cfg_shift = 6'd0; cfg_zp = 8'sd0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (acc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, expected 0", acc_ready); end
        n_chk++; if (out_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b, expected 0", out_enable); end
        n_chk++; if (out_value !== 8'sd0) begin n_fail++; $display("FAIL reset_value: got %0d, expected 0", out_value); end
        n_chk++; if (out_index !== 10'd0) begin n_fail++; $display("FAIL reset_index: got %0d, expected 0", out_index); end
        n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b, expected 0", frame_done); end
        rst = 1'b0; acc_valid = 1'b0;
        #1;
        n_chk++; if (acc_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b, expected 1", acc_ready); end
        model_idx = 0;
        repeat (3) idle();
        n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_no_output: got %0d outputs, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_back_to_back();
        rec_t e, o;
        send(5, 1, 0, 0, 8'sd5, 1);
        send(-3, 1, 0, 0, -8'sd3, 1);
        send(7, 1, 0, 0, 8'sd7, 1);
        send(2, 1, 0, 0, 8'sd2, 1);
        repeat (6) idle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL back_to_back: got %s, expected %s", fmt(o), fmt(e)); end
        end
        n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL back_to_back_extra: got %0d extra outputs, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_round();
        rec_t e, o;
        send(5, 3, 2, 1, 8'sd5, 1);
        send(-6, 3, 2, 1, -8'sd3, 1);
        send(6, 1, 2, 0, 8'sd2, 1);    // 1.5 rounds up to 2
        send(-6, 1, 2, 0, -8'sd1, 1);  // -1.5 rounds up to -1
        repeat (6) idle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL round: got %s, expected %s", fmt(o), fmt(e)); end
        end
        n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL round_extra: got %0d extra outputs, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_saturate();
        rec_t e, o;
        send(1000, 1000, 0, 0, 8'sd127, 1);
        send(-1000, 1000, 0, 0, -8'sd128, 1);
        send(120, 1, 0, 7, 8'sd127, 1);
        send(-120, 1, 0, -8, -8'sd128, 1);
        repeat (6) idle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL saturate: got %s, expected %s", fmt(o), fmt(e)); end
        end
        n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL saturate_extra: got %0d extra outputs, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_gap();
        rec_t e, o;
        send(11, 1, 0, 0, 8'sd11, 1);
        send(12, 1, 0, 0, 8'sd12, 1);
        repeat (3) idle();
        send(13, 1, 0, 0, 8'sd13, 1);
        send(14, 1, 0, 0, 8'sd14, 1);
        repeat (4) idle();
        @(negedge clk);
        n_chk++;
        if (out_enable !== 1'b0 || out_value !== 8'sd0 || out_index !== 10'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_zero: got en=%b val=%0d idx=%0d fd=%b, expected all 0", out_enable, out_value, out_index, frame_done);
        end
        repeat (2) idle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL gap: got %s, expected %s", fmt(o), fmt(e)); end
        end
        n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL gap_extra: got %0d extra outputs, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid();
        rec_t e, o;
        send(21, 1, 0, 0, 8'sd21, 1);
        send(22, 1, 0, 0, 8'sd22, 1);
        repeat (5) idle();
        send(90, 1, 0, 0, 8'sd0, 0);  // in flight when reset hits: discarded
        send(91, 1, 0, 0, 8'sd0, 0);
        @(posedge clk); #1;
        acc_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_idx = 0;
        send(23, 1, 0, 0, 8'sd23, 1);
        send(24, 1, 0, 0, 8'sd24, 1);
        repeat (6) idle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL reset_mid: got %s, expected %s", fmt(o), fmt(e)); end
        end
        n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_mid_extra: got %0d extra outputs, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_relu();
        rec_t e, o;
`ifdef REQUANT_RELU_EN
        send(-50, 1, 0, -10, -8'sd10, 1);
        send(30, 1, 0, -10, 8'sd20, 1);
`else
        send(-50, 1, 0, -10, -8'sd60, 1);
        send(-50, 1, 0, 0, -8'sd50, 1);
`endif
        repeat (6) idle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL relu: got %s, expected %s", fmt(o), fmt(e)); end
        end
        n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL relu_extra: got %0d extra outputs, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_random();
        rec_t e, o;
        int acc, mult, sh, zp;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            acc  = (i % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
            mult = (i % 3 == 0) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 200)) - 100;
            sh   = (i % 2 == 0) ? int'($urandom_range(20, 47)) : int'($urandom_range(0, 8));
            zp   = int'($urandom_range(0, 255)) - 128;
            send(acc, mult, sh, zp, model(acc, mult, sh, zp), 1);
        end
        repeat (6) idle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL random: got %s, expected %s", fmt(o), fmt(e)); end
        end
        n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL random_extra: got %0d extra outputs, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        rst = 1'b1; acc_valid = 1'b0; acc_data = '0;
        cfg_mult = '0; cfg_shift = '0; cfg_zp = '0;
        test_reset();
        test_back_to_back();
        test_round();
        test_saturate();
        test_gap();
        test_reset_mid();
        test_relu();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
